// File: rtl/lsu_ex.sv
// lsu_ex: execute-side load/store unit and write-back pipeline register.
// Issues word-aligned data-memory requests, holds them until acknowledged or timed out.
module lsu_ex #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [2:0]  ex_alu_operation,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_alu_to_reg,
    input  logic [4:0]  ex_dest_reg_sel,
    input  logic [31:0] ex_src1,
    input  logic [31:0] ex_src2,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_alu_result,

    output logic        wb_alu_to_reg,
    output logic [4:0]  wb_dest_reg_sel,
    output logic [31:0] wb_result,
    output logic        wb_mem_to_reg,
    output logic [2:0]  wb_alu_operation,
    output logic [1:0]  wb_read_address,

    output logic        dmem_read_ready,
    input  logic        dmem_read_valid,
    output logic [31:0] dmem_read_address,
    output logic        dmem_write_ready,
    input  logic        dmem_write_valid,
    output logic [31:0] dmem_write_address,
    output logic [31:0] dmem_write_data,
    output logic [3:0]  dmem_write_byte,

    output logic        mem_fault
);

    localparam int unsigned CNT_W = 8;
    localparam logic [2:0]  F3_H  = 3'd1;
    localparam logic [2:0]  F3_W  = 3'd2;
    localparam logic [2:0]  F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               ex_ready_q;
    logic               wb_alu_to_reg_q;
    logic [4:0]         wb_dest_reg_sel_q;
    logic [31:0]        wb_result_q;
    logic               wb_mem_to_reg_q;
    logic [2:0]         wb_alu_operation_q;
    logic [1:0]         wb_read_address_q;
    logic               dmem_read_ready_q;
    logic [31:0]        dmem_read_address_q;
    logic               dmem_write_ready_q;
    logic [31:0]        dmem_write_address_q;
    logic [31:0]        dmem_write_data_q;
    logic [3:0]         dmem_write_byte_q;
    logic               mem_fault_q;

    logic [31:0]        addr;
    logic               is_load;
    logic               is_store;
    logic               bad_f3;
    logic               misaligned;
    logic               acc_fault;
    logic [3:0]         st_be;
    logic [31:0]        st_data;
    logic               accept;
    logic               wait_done;

    // Decode of the presented instruction: address, legality, store lane layout.
    always_comb begin
        addr       = ex_src1 + ex_imm;
        is_load    = ex_mem_read & ~ex_mem_write;
        is_store   = ex_mem_write & ~ex_mem_read;
        bad_f3     = 1'b0;
        misaligned = 1'b0;
        st_be      = 4'b1111;
        st_data    = ex_src2;

        if (is_load) begin
            bad_f3 = (ex_alu_operation == 3'd3) || (ex_alu_operation == 3'd6) ||
                     (ex_alu_operation == 3'd7);
        end else if (is_store) begin
            bad_f3 = (ex_alu_operation > F3_W);
        end

        if ((ex_alu_operation == F3_H) || (is_load && ex_alu_operation == F3_HU)) begin
            misaligned = addr[0];
        end else if (ex_alu_operation == F3_W) begin
            misaligned = (addr[1:0] != 2'b00);
        end

        acc_fault = (ex_mem_read & ex_mem_write) |
                    ((is_load | is_store) & (bad_f3 | misaligned));

        case (ex_alu_operation[1:0])
            2'd0: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = {4{ex_src2[7:0]}};
            end
            2'd1: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{ex_src2[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = ex_src2;
            end
        endcase
    end

    assign accept    = ex_valid & ex_ready_q & (state_q == IDLE);
    assign wait_done = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

    // State machine with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= IDLE;
            wait_cnt_q           <= '0;
            ex_ready_q           <= 1'b0;
            wb_alu_to_reg_q      <= 1'b0;
            wb_dest_reg_sel_q    <= '0;
            wb_result_q          <= '0;
            wb_mem_to_reg_q      <= 1'b0;
            wb_alu_operation_q   <= '0;
            wb_read_address_q    <= '0;
            dmem_read_ready_q    <= 1'b0;
            dmem_read_address_q  <= '0;
            dmem_write_ready_q   <= 1'b0;
            dmem_write_address_q <= '0;
            dmem_write_data_q    <= '0;
            dmem_write_byte_q    <= '0;
            mem_fault_q          <= 1'b0;
        end else begin
            wb_alu_to_reg_q <= 1'b0;
            mem_fault_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    ex_ready_q <= 1'b1;
                    if (accept) begin
                        if (acc_fault) begin
                            mem_fault_q <= 1'b1;
                        end else if (is_load) begin
                            dmem_read_address_q <= {addr[31:2], 2'b00};
                            dmem_read_ready_q   <= 1'b1;
                            wb_mem_to_reg_q     <= 1'b1;
                            wb_dest_reg_sel_q   <= ex_dest_reg_sel;
                            wb_alu_operation_q  <= ex_alu_operation;
                            wb_read_address_q   <= addr[1:0];
                            wait_cnt_q          <= '0;
                            ex_ready_q          <= 1'b0;
                            state_q             <= RD_WAIT;
                        end else if (is_store) begin
                            dmem_write_address_q <= {addr[31:2], 2'b00};
                            dmem_write_data_q    <= st_data;
                            dmem_write_byte_q    <= st_be;
                            dmem_write_ready_q   <= 1'b1;
                            wait_cnt_q           <= '0;
                            ex_ready_q           <= 1'b0;
                            state_q              <= WR_WAIT;
                        end else begin
                            wb_result_q       <= ex_alu_result;
                            wb_alu_to_reg_q   <= ex_alu_to_reg & (ex_dest_reg_sel != 5'd0);
                            wb_dest_reg_sel_q <= ex_dest_reg_sel;
                            wb_mem_to_reg_q   <= 1'b0;
                        end
                    end
                end
                RD_WAIT: begin
                    // Acknowledge wins over a simultaneous timeout.
                    if (dmem_read_valid || wait_done) begin
                        mem_fault_q       <= ~dmem_read_valid;
                        dmem_read_ready_q <= 1'b0;
                        wb_mem_to_reg_q   <= 1'b0;
                        wait_cnt_q        <= '0;
                        ex_ready_q        <= 1'b1;
                        state_q           <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (dmem_write_valid || wait_done) begin
                        mem_fault_q          <= ~dmem_write_valid;
                        dmem_write_ready_q   <= 1'b0;
                        dmem_write_address_q <= '0;
                        dmem_write_data_q    <= '0;
                        dmem_write_byte_q    <= '0;
                        wait_cnt_q           <= '0;
                        ex_ready_q           <= 1'b1;
                        state_q              <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ex_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Load write-back enable is live only in the acknowledge cycle, when load data exists.
    assign wb_alu_to_reg = wb_alu_to_reg_q |
                           ((state_q == RD_WAIT) & dmem_read_valid & (wb_dest_reg_sel_q != 5'd0));

    assign ex_ready           = ex_ready_q;
    assign wb_dest_reg_sel    = wb_dest_reg_sel_q;
    assign wb_result          = wb_result_q;
    assign wb_mem_to_reg      = wb_mem_to_reg_q;
    assign wb_alu_operation   = wb_alu_operation_q;
    assign wb_read_address    = wb_read_address_q;
    assign dmem_read_ready    = dmem_read_ready_q;
    assign dmem_read_address  = dmem_read_address_q;
    assign dmem_write_ready   = dmem_write_ready_q;
    assign dmem_write_address = dmem_write_address_q;
    assign dmem_write_data    = dmem_write_data_q;
    assign dmem_write_byte    = dmem_write_byte_q;
    assign mem_fault          = mem_fault_q;

endmodule

// File: tb/tb_lsu_ex.sv
// tb_lsu_ex: directed scenario bench for lsu_ex with hand-computed expectations.
module tb_lsu_ex;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_alu_operation;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_alu_to_reg;
    logic [4:0]  ex_dest_reg_sel;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [31:0] ex_imm;
    logic [31:0] ex_alu_result;
    logic        wb_alu_to_reg;
    logic [4:0]  wb_dest_reg_sel;
    logic [31:0] wb_result;
    logic        wb_mem_to_reg;
    logic [2:0]  wb_alu_operation;
    logic [1:0]  wb_read_address;
    logic        dmem_read_ready;
    logic        dmem_read_valid;
    logic [31:0] dmem_read_address;
    logic        dmem_write_ready;
    logic        dmem_write_valid;
    logic [31:0] dmem_write_address;
    logic [31:0] dmem_write_data;
    logic [3:0]  dmem_write_byte;
    logic        mem_fault;

    int errors = 0;
    int checks = 0;

    lsu_ex #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_operation(ex_alu_operation), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_to_reg(ex_alu_to_reg),
        .ex_dest_reg_sel(ex_dest_reg_sel), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
        .wb_alu_to_reg(wb_alu_to_reg), .wb_dest_reg_sel(wb_dest_reg_sel),
        .wb_result(wb_result), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_alu_operation(wb_alu_operation), .wb_read_address(wb_read_address),
        .dmem_read_ready(dmem_read_ready), .dmem_read_valid(dmem_read_valid),
        .dmem_read_address(dmem_read_address), .dmem_write_ready(dmem_write_ready),
        .dmem_write_valid(dmem_write_valid), .dmem_write_address(dmem_write_address),
        .dmem_write_data(dmem_write_data), .dmem_write_byte(dmem_write_byte),
        .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid         = 1'b0;
        ex_alu_operation = 3'd0;
        ex_mem_read      = 1'b0;
        ex_mem_write     = 1'b0;
        ex_alu_to_reg    = 1'b0;
        ex_dest_reg_sel  = 5'd0;
        ex_src1          = 32'd0;
        ex_src2          = 32'd0;
        ex_imm           = 32'd0;
        ex_alu_result    = 32'd0;
        dmem_read_valid  = 1'b0;
        dmem_write_valid = 1'b0;
    endtask

    task automatic issue(input logic mr, input logic mw, input logic [2:0] op,
                         input logic [4:0] rd, input logic [31:0] src1,
                         input logic [31:0] imm, input logic [31:0] src2,
                         input logic [31:0] alu_res, input logic to_reg);
        ex_valid         = 1'b1;
        ex_mem_read      = mr;
        ex_mem_write     = mw;
        ex_alu_operation = op;
        ex_dest_reg_sel  = rd;
        ex_src1          = src1;
        ex_imm           = imm;
        ex_src2          = src2;
        ex_alu_result    = alu_res;
        ex_alu_to_reg    = to_reg;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ex_ready, wb_alu_to_reg, wb_mem_to_reg, dmem_read_ready, dmem_write_ready, mem_fault} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {ex_ready, wb_alu_to_reg, wb_mem_to_reg, dmem_read_ready, dmem_write_ready, mem_fault});
        end
        checks++;
        if ({wb_result, dmem_read_address, dmem_write_data, dmem_write_byte} !== 100'd0) begin
            errors++;
            $display("FAIL reset_buses: wb_result=%h rd_addr=%h wr_data=%h be=%b want 0",
                     wb_result, dmem_read_address, dmem_write_data, dmem_write_byte);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", ex_ready);
        end
    endtask

    task automatic test_alu();
        issue(1'b0, 1'b0, 3'd0, 5'd5, 32'd0, 32'd0, 32'd0, 32'h1234, 1'b1);
        tick();
        checks++;
        if ({wb_alu_to_reg, wb_mem_to_reg, wb_dest_reg_sel, wb_result, ex_ready} !== {1'b1, 1'b0, 5'd5, 32'h1234, 1'b1}) begin
            errors++;
            $display("FAIL alu_rd5: to_reg=%b mem_to_reg=%b rd=%0d result=%h ready=%b want 1 0 5 00001234 1",
                     wb_alu_to_reg, wb_mem_to_reg, wb_dest_reg_sel, wb_result, ex_ready);
        end
        issue(1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h55, 1'b1);
        tick();
        checks++;
        if ({wb_alu_to_reg, wb_result} !== {1'b0, 32'h55}) begin
            errors++;
            $display("FAIL alu_rd0: to_reg=%b result=%h want 0 00000055", wb_alu_to_reg, wb_result);
        end
        issue(1'b0, 1'b0, 3'd0, 5'd7, 32'd0, 32'd0, 32'd0, 32'hA, 1'b1);
        tick();
        checks++;
        if ({wb_alu_to_reg, wb_dest_reg_sel, wb_result} !== {1'b1, 5'd7, 32'hA}) begin
            errors++;
            $display("FAIL alu_back_to_back: to_reg=%b rd=%0d result=%h want 1 7 0000000a",
                     wb_alu_to_reg, wb_dest_reg_sel, wb_result);
        end
        clear_inputs();
        tick();
        checks++;
        if (wb_alu_to_reg !== 1'b0) begin
            errors++;
            $display("FAIL alu_one_cycle: to_reg=%b want 0", wb_alu_to_reg);
        end
    endtask

    task automatic test_load();
        // LB at 0x1000+3, acknowledge in the third wait cycle
        issue(1'b1, 1'b0, 3'd0, 5'd9, 32'h1000, 32'd3, 32'd0, 32'd0, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if ({dmem_read_ready, dmem_read_address, wb_read_address, wb_alu_operation, wb_mem_to_reg, ex_ready, wb_alu_to_reg}
            !== {1'b1, 32'h1000, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lb_request: req=%b addr=%h ra=%0d op=%0d m2r=%b ready=%b to_reg=%b want 1 00001000 3 0 1 0 0",
                     dmem_read_ready, dmem_read_address, wb_read_address, wb_alu_operation,
                     wb_mem_to_reg, ex_ready, wb_alu_to_reg);
        end
        tick();
        checks++;
        if ({dmem_read_ready, dmem_read_address, wb_alu_to_reg} !== {1'b1, 32'h1000, 1'b0}) begin
            errors++;
            $display("FAIL lb_hold: req=%b addr=%h to_reg=%b want 1 00001000 0",
                     dmem_read_ready, dmem_read_address, wb_alu_to_reg);
        end
        tick();
        dmem_read_valid = 1'b1;
        #1;
        checks++;
        if ({wb_alu_to_reg, wb_dest_reg_sel, ex_ready} !== {1'b1, 5'd9, 1'b0}) begin
            errors++;
            $display("FAIL lb_ack_cycle: to_reg=%b rd=%0d ready=%b want 1 9 0",
                     wb_alu_to_reg, wb_dest_reg_sel, ex_ready);
        end
        tick();
        dmem_read_valid = 1'b0;
        #1;
        checks++;
        if ({ex_ready, dmem_read_ready, wb_mem_to_reg, wb_alu_to_reg} !== 4'b1000) begin
            errors++;
            $display("FAIL lb_complete: ready=%b req=%b m2r=%b to_reg=%b want 1 0 0 0",
                     ex_ready, dmem_read_ready, wb_mem_to_reg, wb_alu_to_reg);
        end
        // LHU at 2 + (-4) wraps to 0xFFFFFFFE; earliest acknowledge
        issue(1'b1, 1'b0, 3'd5, 5'd3, 32'h2, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1);
        tick();
        clear_inputs();
        dmem_read_valid = 1'b1;
        #1;
        checks++;
        if ({dmem_read_address, wb_read_address, wb_alu_operation, wb_alu_to_reg}
            !== {32'hFFFF_FFFC, 2'd2, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL lhu_wrap: addr=%h ra=%0d op=%0d to_reg=%b want fffffffc 2 5 1",
                     dmem_read_address, wb_read_address, wb_alu_operation, wb_alu_to_reg);
        end
        tick();
        dmem_read_valid = 1'b0;
        #1;
        checks++;
        if ({ex_ready, dmem_read_ready} !== 2'b10) begin
            errors++;
            $display("FAIL lhu_min_occupancy: ready=%b req=%b want 1 0", ex_ready, dmem_read_ready);
        end
        // LW to rd 0 never writes back
        issue(1'b1, 1'b0, 3'd2, 5'd0, 32'h3000, 32'd8, 32'd0, 32'd0, 1'b1);
        tick();
        clear_inputs();
        dmem_read_valid = 1'b1;
        #1;
        checks++;
        if ({dmem_read_address, wb_alu_to_reg} !== {32'h3008, 1'b0}) begin
            errors++;
            $display("FAIL lw_rd0: addr=%h to_reg=%b want 00003008 0", dmem_read_address, wb_alu_to_reg);
        end
        tick();
        dmem_read_valid = 1'b0;
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, 3'd1, 5'd4, 32'h2000, 32'd2, 32'hAABB_CCDD, 32'd0, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if ({dmem_write_ready, dmem_write_address, dmem_write_byte, dmem_write_data, ex_ready, wb_alu_to_reg}
            !== {1'b1, 32'h2000, 4'b1100, 32'hCCDD_CCDD, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sh_request: req=%b addr=%h be=%b data=%h ready=%b to_reg=%b want 1 00002000 1100 ccddccdd 0 0",
                     dmem_write_ready, dmem_write_address, dmem_write_byte, dmem_write_data, ex_ready, wb_alu_to_reg);
        end
        tick();
        // A read acknowledge while waiting on a write must be ignored
        dmem_read_valid  = 1'b1;
        dmem_write_valid = 1'b1;
        #1;
        checks++;
        if ({dmem_write_ready, dmem_write_address, dmem_write_byte, dmem_write_data, wb_alu_to_reg}
            !== {1'b1, 32'h2000, 4'b1100, 32'hCCDD_CCDD, 1'b0}) begin
            errors++;
            $display("FAIL sh_hold: req=%b addr=%h be=%b data=%h to_reg=%b want 1 00002000 1100 ccddccdd 0",
                     dmem_write_ready, dmem_write_address, dmem_write_byte, dmem_write_data, wb_alu_to_reg);
        end
        tick();
        dmem_read_valid  = 1'b0;
        dmem_write_valid = 1'b0;
        #1;
        checks++;
        if ({dmem_write_ready, dmem_write_address, dmem_write_byte, dmem_write_data, ex_ready, dmem_read_ready}
            !== {1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sh_complete: req=%b addr=%h be=%b data=%h ready=%b rreq=%b want 0 0 0 0 1 0",
                     dmem_write_ready, dmem_write_address, dmem_write_byte, dmem_write_data, ex_ready, dmem_read_ready);
        end
        issue(1'b0, 1'b1, 3'd0, 5'd4, 32'h2000, 32'd1, 32'hAABB_CCDD, 32'd0, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if ({dmem_write_address, dmem_write_byte, dmem_write_data} !== {32'h2000, 4'b0010, 32'hDDDD_DDDD}) begin
            errors++;
            $display("FAIL sb_lanes: addr=%h be=%b data=%h want 00002000 0010 dddddddd",
                     dmem_write_address, dmem_write_byte, dmem_write_data);
        end
        dmem_write_valid = 1'b1;
        tick();
        dmem_write_valid = 1'b0;
        issue(1'b0, 1'b1, 3'd2, 5'd4, 32'h3000, 32'd4, 32'h1234_5678, 32'd0, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if ({dmem_write_address, dmem_write_byte, dmem_write_data} !== {32'h3004, 4'b1111, 32'h1234_5678}) begin
            errors++;
            $display("FAIL sw_lanes: addr=%h be=%b data=%h want 00003004 1111 12345678",
                     dmem_write_address, dmem_write_byte, dmem_write_data);
        end
        dmem_write_valid = 1'b1;
        tick();
        dmem_write_valid = 1'b0;
        #1;
        checks++;
        if ({ex_ready, dmem_write_ready, mem_fault} !== 3'b100) begin
            errors++;
            $display("FAIL sw_complete: ready=%b req=%b fault=%b want 1 0 0", ex_ready, dmem_write_ready, mem_fault);
        end
    endtask

    task automatic test_faults();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: issue(1'b1, 1'b0, 3'd2, 5'd5, 32'h1000, 32'd1, 32'd0, 32'hEE, 1'b1); // LW 0x1001
                1: issue(1'b0, 1'b1, 3'd1, 5'd5, 32'h2000, 32'd1, 32'd0, 32'hEE, 1'b1); // SH 0x2001
                2: issue(1'b1, 1'b0, 3'd3, 5'd5, 32'h1000, 32'd0, 32'd0, 32'hEE, 1'b1); // load f3=3
                3: issue(1'b1, 1'b1, 3'd2, 5'd5, 32'h1000, 32'd0, 32'd0, 32'hEE, 1'b1); // rd and wr
                4: issue(1'b0, 1'b1, 3'd4, 5'd5, 32'h1000, 32'd0, 32'd0, 32'hEE, 1'b1); // store f3=4
                default: issue(1'b1, 1'b0, 3'd1, 5'd5, 32'h1001, 32'd2, 32'd0, 32'hEE, 1'b1); // LH 0x1003
            endcase
            tick();
            clear_inputs();
            checks++;
            if ({mem_fault, dmem_read_ready, dmem_write_ready, ex_ready, wb_alu_to_reg} !== 5'b10010) begin
                errors++;
                $display("FAIL fault_case%0d: fault=%b rreq=%b wreq=%b ready=%b to_reg=%b want 1 0 0 1 0",
                         i, mem_fault, dmem_read_ready, dmem_write_ready, ex_ready, wb_alu_to_reg);
            end
            tick();
            checks++;
            if ({mem_fault, ex_ready} !== 2'b01) begin
                errors++;
                $display("FAIL fault_pulse%0d: fault=%b ready=%b want 0 1", i, mem_fault, ex_ready);
            end
        end
    endtask

    task automatic test_timeout();
        issue(1'b1, 1'b0, 3'd2, 5'd6, 32'h4000, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        clear_inputs();
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if ({dmem_read_ready, dmem_read_address, mem_fault, ex_ready} !== {1'b1, 32'h4000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL timeout_hold_c%0d: req=%b addr=%h fault=%b ready=%b want 1 00004000 0 0",
                         c, dmem_read_ready, dmem_read_address, mem_fault, ex_ready);
            end
            tick();
        end
        checks++;
        if ({dmem_read_ready, mem_fault, ex_ready, wb_alu_to_reg, wb_mem_to_reg} !== 5'b01100) begin
            errors++;
            $display("FAIL timeout_drop: req=%b fault=%b ready=%b to_reg=%b m2r=%b want 0 1 1 0 0",
                     dmem_read_ready, mem_fault, ex_ready, wb_alu_to_reg, wb_mem_to_reg);
        end
        tick();
        checks++;
        if (mem_fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: fault=%b want 0", mem_fault);
        end
        // Acknowledge on the 15th wait cycle completes normally
        issue(1'b1, 1'b0, 3'd2, 5'd6, 32'h4000, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        clear_inputs();
        repeat (14) tick();
        dmem_read_valid = 1'b1;
        #1;
        checks++;
        if ({dmem_read_ready, wb_alu_to_reg} !== 2'b11) begin
            errors++;
            $display("FAIL ack15_cycle: req=%b to_reg=%b want 1 1", dmem_read_ready, wb_alu_to_reg);
        end
        tick();
        dmem_read_valid = 1'b0;
        #1;
        checks++;
        if ({mem_fault, ex_ready, dmem_read_ready} !== 3'b010) begin
            errors++;
            $display("FAIL ack15_complete: fault=%b ready=%b req=%b want 0 1 0", mem_fault, ex_ready, dmem_read_ready);
        end
        // Store timeout also drops after 15 wait cycles
        issue(1'b0, 1'b1, 3'd2, 5'd6, 32'h5000, 32'd0, 32'h77, 32'd0, 1'b1);
        tick();
        clear_inputs();
        repeat (14) tick();
        checks++;
        if ({dmem_write_ready, mem_fault} !== 2'b10) begin
            errors++;
            $display("FAIL wr_timeout_c15: req=%b fault=%b want 1 0", dmem_write_ready, mem_fault);
        end
        tick();
        checks++;
        if ({dmem_write_ready, dmem_write_byte, mem_fault, ex_ready} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wr_timeout_drop: req=%b be=%b fault=%b ready=%b want 0 0000 1 1",
                     dmem_write_ready, dmem_write_byte, mem_fault, ex_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        issue(1'b1, 1'b0, 3'd0, 5'd8, 32'h6000, 32'd1, 32'd0, 32'd0, 1'b1);
        tick();
        clear_inputs();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({dmem_read_ready, dmem_read_address, wb_mem_to_reg, ex_ready, wb_dest_reg_sel}
            !== {1'b0, 32'd0, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_mid_wait: req=%b addr=%h m2r=%b ready=%b rd=%0d want 0 0 0 0 0",
                     dmem_read_ready, dmem_read_address, wb_mem_to_reg, ex_ready, wb_dest_reg_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        dmem_read_valid = 1'b1;
        #1;
        checks++;
        if (wb_alu_to_reg !== 1'b0) begin
            errors++;
            $display("FAIL late_ack_no_wb: to_reg=%b want 0", wb_alu_to_reg);
        end
        tick();
        checks++;
        if ({wb_alu_to_reg, ex_ready, dmem_read_ready} !== 3'b010) begin
            errors++;
            $display("FAIL after_reset_idle: to_reg=%b ready=%b req=%b want 0 1 0",
                     wb_alu_to_reg, ex_ready, dmem_read_ready);
        end
        dmem_read_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_faults();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ex.md
# lsu_ex

Execute-side load/store and pipeline-register stage, directly upstream of the write-back stage. Accepts one decoded instruction per handshake and computes the effective address. Issues word-aligned data-memory read/write requests with byte enables and holds them until the memory acknowledges. Presents the registered write-back fields (`wb_*`) that the write-back stage consumes for register-file update and load-data extraction.

## Interface
- MAX_WAIT, 15: cycles a memory request may wait for acknowledge before it is abandoned; legal range is 1..255.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- ex_valid  in  1  an instruction is presented.
- ex_ready  out  1  stage can accept; instruction transfers on a clk edge with ex_valid & ex_ready.
- ex_alu_operation  in  3  funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2.
- ex_mem_read  in  1  load instruction.
- ex_mem_write  in  1  store instruction.
- ex_alu_to_reg  in  1  instruction writes rd.
- ex_dest_reg_sel  in  5  rd index.
- ex_src1  in  32  base register value.
- ex_src2  in  32  store data.
- ex_imm  in  32  sign-extended offset.
- ex_alu_result  in  32  result for non-memory instructions.
- wb_alu_to_reg  out  1  write-back enable.
- wb_dest_reg_sel  out  5  rd to write.
- wb_result  out  32  ALU result.
- wb_mem_to_reg  out  1  select load data.
- wb_alu_operation  out  3  load funct3 for extraction.
- wb_read_address  out  2  effective address [1:0].
- dmem_read_ready  out  1  read request.
- dmem_read_valid  in  1  read acknowledge; read data is valid in this cycle only.
- dmem_read_address  out  32  {addr[31:2],2'b00}.
- dmem_write_ready  out  1  write request.
- dmem_write_valid  in  1  write acknowledge.
- dmem_write_address  out  32  {addr[31:2],2'b00}.
- dmem_write_data  out  32  lane-replicated store data.
- dmem_write_byte  out  4  byte enables.
- mem_fault  out  1  one-cycle pulse: misaligned access, illegal funct3, read and write both set, or timeout.

## Operation
- Reset values: all outputs 0; state IDLE; wait counter 0.
- States:
  - IDLE: ex_ready=1.
  - RD_WAIT: ex_ready=0.
  - WR_WAIT: ex_ready=0.
- Address arithmetic: addr = ex_src1 + ex_imm, modulo 2^32; no overflow detection.
- Accept in IDLE, non-memory instruction (ex_mem_read=ex_mem_write=0):
  - Next cycle: wb_result=ex_alu_result, wb_alu_to_reg=ex_alu_to_reg & (ex_dest_reg_sel!=0), wb_mem_to_reg=0.
  - Stays IDLE.
- Fault on accept; state stays IDLE, no request issued, no write-back, mem_fault pulses for one cycle:
  - Both ex_mem_read and ex_mem_write set.
  - Load funct3 in {3,6,7}; store funct3 > 2.
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
- Load accept:
  - Registers dmem_read_address, wb_dest_reg_sel, wb_alu_operation, wb_read_address=addr[1:0].
  - Sets wb_mem_to_reg=1 and dmem_read_ready=1; enters RD_WAIT.
  - wb_alu_to_reg in RD_WAIT = dmem_read_valid & (rd!=0). This is the only combinational output path, because load data exists only in the acknowledge cycle.
  - On acknowledge: next state IDLE; dmem_read_ready and wb_mem_to_reg clear.
- Store accept:
  - SB: dmem_write_byte=4'b0001<<addr[1:0], data={4{src2[7:0]}}.
  - SH: dmem_write_byte=addr[1]?4'b1100:4'b0011, data={2{src2[15:0]}}.
  - SW: dmem_write_byte=4'b1111, data=src2.
  - Sets dmem_write_ready=1; enters WR_WAIT.
  - On dmem_write_valid: next state IDLE; request and all dmem_write_* outputs clear to 0.
  - Stores never assert wb_alu_to_reg.
- Request stability: address, data and byte enables are held constant for the whole wait.
- Acknowledges outside the matching wait state are ignored.
- Timeout:
  - The wait counter increments each wait cycle without acknowledge.
  - When it reaches MAX_WAIT, the request is dropped, mem_fault pulses, no write-back occurs, and the next state is IDLE.
  - An acknowledge in the same cycle the count reaches MAX_WAIT wins: the operation completes normally with no fault.
- Reset mid-wait: the request is dropped asynchronously; no write-back.

## Timing
- Accept at edge N.
- ALU result: wb fields valid during cycle N+1 only; back-to-back accepts give one result per cycle.
- Memory request: asserted from cycle N+1.
- Acknowledge: the earliest legal acknowledge is in cycle N+1.
- After acknowledge in cycle k: ex_ready is high in cycle k+1.
- Minimum occupancy for loads and stores: 2 cycles.
- ex_ready depends only on state; it is not combinational from ex_valid.

## Test plan
- ALU: accept ex_alu_result=0x1234, rd=5 -> next cycle wb_alu_to_reg=1, wb_result=0x1234, wb_mem_to_reg=0; rd=0 -> wb_alu_to_reg=0.
- LB: src1=0x1000, imm=3, ack after 3 cycles -> dmem_read_address=0x1000, wb_read_address=3, wb_alu_operation=0; wb_alu_to_reg high only in the ack cycle; ex_ready=0 until the following cycle.
- SH at 0x2002, src2=0xAABBCCDD -> dmem_write_byte=1100, dmem_write_data=0xCCDDCCDD, address 0x2000; SB at 0x2001 -> byte enables 0010, data 0xDDDDDDDD.
- Misaligned LW at 0x1001, SH at 0x2001, and funct3=3 load -> mem_fault pulse, no dmem request, ex_ready stays 1.
- No ack with MAX_WAIT=15 -> request held 15 cycles, then mem_fault pulse and IDLE; variant with ack on the 15th cycle -> normal completion, no fault.
- Assert reset during RD_WAIT -> all outputs 0 immediately; a later dmem_read_valid produces no wb_alu_to_reg.
